// File: rtl/lcd_pkg.sv
// Shared definitions for the UC1611 LCD write path: arbiter FSM states,
// CD levels, command FIFO entry layout and common controller opcodes.
package lcd_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_STROBE,
    ARB_HOLD
  } arb_state_t;

  localparam logic LCD_CD_CMD  = 1'b0;
  localparam logic LCD_CD_DATA = 1'b1;

  localparam logic [7:0] SET_GAIN_POT    = 8'h81;
  localparam logic [7:0] SYS_RESET       = 8'he2;
  localparam logic [7:0] SET_SCROLL_LINE = 8'h40;
  localparam logic [7:0] SET_DISPLAY_EN  = 8'haf;

  typedef struct packed {
    logic       cd;
    logic [7:0] data;
  } cmd_entry_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous {cd,data} command FIFO; power-of-2 depth so pointers wrap
// naturally. Push is ignored when full, pop is ignored when empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  cmd_entry_t push_entry,
  input  logic       pop,
  output cmd_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// UC1611 parallel write-bus owner: pixel stream has priority, commands go out
// only in vblank with no pixel pending. LCD_ARB_CMD_FIFO_EN adds a command FIFO.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW    = 1,
  parameter int unsigned WR_HIGH   = 1,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       px_valid,
  input  logic [7:0] px_data,
  output logic       px_ready,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       cmd_cd,
  output logic       cmd_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_cd,
  output logic       lcd_write_n,
  output logic       busy
);

  localparam int unsigned PHASE_MAX = max_u(WR_LOW, WR_HIGH);
  localparam int unsigned CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(WR_LOW - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(WR_HIGH - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic       idle;
  logic       cmd_grant;
  logic       head_valid;
  cmd_entry_t head;
  logic       take_px;
  logic       take_cmd;

  assign idle      = (state == ARB_IDLE);
  assign px_ready  = idle;
  assign cmd_grant = idle && vblank && !px_valid;
  assign take_px   = idle && px_valid;
  assign take_cmd  = cmd_grant && head_valid;
  assign busy      = !idle;

`ifdef LCD_ARB_CMD_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  assign cmd_ready  = !fifo_full;
  assign head_valid = !fifo_empty;

  lcd_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && !fifo_full),
    .push_entry('{cd: cmd_cd, data: cmd_data}),
    .pop       (take_cmd),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  assign cmd_ready  = cmd_grant;
  assign head_valid = cmd_valid;
  assign head       = '{cd: cmd_cd, data: cmd_data};
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ARB_IDLE: begin
        if (take_px || take_cmd) begin
          state_next = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        state_next = ARB_STROBE;
        cnt_next   = '0;
      end
      ARB_STROBE: begin
        if (cnt == LOW_LAST) begin
          state_next = ARB_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ARB_HOLD: begin
        if (cnt == HIGH_LAST) begin
          state_next = ARB_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Strobe is registered from the next state so the pin is glitch-free yet
  // still low for exactly the STROBE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      lcd_write_n <= 1'b1;
      lcd_cd      <= LCD_CD_CMD;
      lcd_data    <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      lcd_write_n <= (state_next != ARB_STROBE);
      if (take_px) begin
        lcd_data <= px_data;
        lcd_cd   <= LCD_CD_DATA;
      end else if (take_cmd) begin
        lcd_data <= head.data;
        lcd_cd   <= head.cd;
      end
    end
  end

endmodule
